// File: rtl/filter_capture_buffer_pkg.sv
// Shared types and defaults for the filter output capture buffer.
package filter_capture_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int NUM_SAMPLES_DEF = 250;
  localparam int ADDR_W_DEF = 8;
  localparam int SUM_W_DEF = 24;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    HOLD,
    READ
  } cap_state_t;

  // Sign-extend the low w bits of d to 64 bits.
  function automatic logic [63:0] sext64(
    input logic [63:0] d,
    input int unsigned w
  );
    logic signed [63:0] t;
    t = $signed(d << (64 - w));
    return t >>> (64 - w);
  endfunction

endpackage

// File: rtl/filter_capture_buffer_if.sv
// Readout valid/ready port of the capture buffer.
interface filter_capture_buffer_if
  import filter_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;

  modport master (
    output rd_valid,
    output rd_data,
    output rd_last,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_data,
    input  rd_last,
    output rd_ready
  );

endinterface

// File: rtl/capture_ram.sv
// Register array: one synchronous write port, one async read port.
module capture_ram
  import filter_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = NUM_SAMPLES_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/filter_capture_buffer.sv
// Captures NUM_SAMPLES filter outputs and streams them back in order.
module filter_capture_buffer
  import filter_capture_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int NUM_SAMPLES = NUM_SAMPLES_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int SUM_W       = SUM_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              arm,
  input  logic              clk_enable,
  input  logic [DATA_W-1:0] Output1,
  output logic              capture_done,
  output logic [ADDR_W-1:0] sample_count,
  output logic [SUM_W-1:0]  checksum,
  output logic              overflow,
  input  logic              start_read,
  filter_capture_buffer_if.master rd
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_SAMPLES - 1);
  localparam logic [ADDR_W-1:0] COUNT =
    ADDR_W'(NUM_SAMPLES);

  cap_state_t        state;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] ram_q;
  logic              wr_en;

  // The write pointer is always equal to the count.
  assign wr_addr = sample_count;
  assign wr_en   = (state == CAPTURE) && clk_enable && !arm;

  capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (NUM_SAMPLES),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (Output1),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      capture_done <= 1'b0;
      sample_count <= '0;
      checksum     <= '0;
      overflow     <= 1'b0;
      rd_addr      <= '0;
      rd.rd_valid  <= 1'b0;
      rd.rd_data   <= '0;
      rd.rd_last   <= 1'b0;
    end else if (arm) begin
      // arm restarts from any state and wins over everything
      state        <= CAPTURE;
      capture_done <= 1'b0;
      sample_count <= '0;
      checksum     <= '0;
      overflow     <= 1'b0;
      rd.rd_valid  <= 1'b0;
      rd.rd_last   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        CAPTURE: begin
          if (clk_enable) begin
            sample_count <= sample_count + 1'b1;
            checksum <= checksum +
              SUM_W'(sext64(64'(Output1), DATA_W));
            if (sample_count == LAST) begin
              state        <= HOLD;
              capture_done <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (clk_enable) overflow <= 1'b1;
          if (start_read) begin
            state   <= READ;
            rd_addr <= '0;
          end
        end
        READ: begin
          if (clk_enable) overflow <= 1'b1;
          if (rd.rd_valid && rd.rd_ready && rd.rd_last) begin
            state       <= HOLD;
            rd.rd_valid <= 1'b0;
            rd.rd_last  <= 1'b0;
          end else if (!rd.rd_valid || rd.rd_ready) begin
            rd.rd_valid <= rd_addr < COUNT;
            if (rd_addr < COUNT) begin
              rd.rd_data <= ram_q;
              rd.rd_last <= rd_addr == LAST;
              rd_addr    <= rd_addr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_capture_buffer.sv
// Randomized self-checking bench for filter_capture_buffer.
module tb_filter_capture_buffer;

  localparam int N = 250;

  logic        clk = 1'b0;
  logic        resetn;
  logic        arm;
  logic        clk_enable;
  logic [15:0] Output1;
  logic        capture_done;
  logic [7:0]  sample_count;
  logic [23:0] checksum;
  logic        overflow;
  logic        start_read;

  int total = 0;
  int bad = 0;

  logic [15:0] cap_q[$];
  longint      sum_model;

  filter_capture_buffer_if #(.DATA_W(16)) rd_if ();

  filter_capture_buffer dut (
    .clk          (clk),
    .resetn       (resetn),
    .arm          (arm),
    .clk_enable   (clk_enable),
    .Output1      (Output1),
    .capture_done (capture_done),
    .sample_count (sample_count),
    .checksum     (checksum),
    .overflow     (overflow),
    .start_read   (start_read),
    .rd           (rd_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse arm with a coincident strobe, which must not be captured.
  task automatic arm_pulse();
    arm = 1'b1;
    clk_enable = 1'b1;
    Output1 = 16'($urandom);
    tick();
    arm = 1'b0;
    clk_enable = 1'b0;
    cap_q.delete();
    sum_model = 0;
  endtask

  // mode 0: value i, 1: 0xFF00, 2: random
  task automatic feed(input int n, input int mode,
                      input int gap, input bit rnd_gap);
    for (int i = 0; i < n; i++) begin
      logic [15:0] v;
      int g;
      v = mode == 0 ? 16'(i) :
          mode == 1 ? 16'hFF00 : 16'($urandom);
      g = rnd_gap ? int'($urandom_range(0, gap)) : gap;
      for (int k = 0; k < g; k++) begin
        clk_enable = 1'b0;
        Output1 = 16'($urandom);
        tick();
      end
      clk_enable = 1'b1;
      Output1 = v;
      tick();
      cap_q.push_back(v);
      sum_model += longint'($signed(v));
    end
    clk_enable = 1'b0;
  endtask

  task automatic read_out(input bit bp, input int abort_at,
                          output int cycles, output int beats);
    logic [15:0] pd;
    logic        pl;
    bit          pending;
    bit          done;
    start_read = 1'b1;
    tick();
    start_read = 1'b0;
    cycles = 0;
    beats = 0;
    pending = 0;
    done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      rd_if.rd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (abort_at >= 0 && beats == abort_at) begin
        arm = 1'b1;
        rd_if.rd_ready = 1'b1;
        tick();
        arm = 1'b0;
        cap_q.delete();
        sum_model = 0;
        total++;
        if (rd_if.rd_valid !== 1'b0 || sample_count !== 8'd0 ||
            capture_done !== 1'b0) begin
          bad++;
          $display("FAIL abort: valid=%b cnt=%0d done=%b want 0 0 0",
                   rd_if.rd_valid, sample_count, capture_done);
        end
        return;
      end
      if (rd_if.rd_valid && rd_if.rd_ready) begin
        total++;
        if (beats >= cap_q.size() ||
            rd_if.rd_data !== cap_q[beats] ||
            rd_if.rd_last !== (beats == N - 1)) begin
          bad++;
          $display("FAIL beat %0d: data=%h last=%b want %h %b",
                   beats, rd_if.rd_data, rd_if.rd_last,
                   beats < cap_q.size() ? cap_q[beats] : 16'hx,
                   beats == N - 1);
        end
        beats++;
        if (rd_if.rd_last) done = 1;
      end
      pending = rd_if.rd_valid && !rd_if.rd_ready;
      pd = rd_if.rd_data;
      pl = rd_if.rd_last;
      tick();
      cycles++;
      if (pending) begin
        total++;
        if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== pd ||
            rd_if.rd_last !== pl) begin
          bad++;
          $display("FAIL stall: v=%b d=%h l=%b want 1 %h %b",
                   rd_if.rd_valid, rd_if.rd_data, rd_if.rd_last,
                   pd, pl);
        end
      end
    end
    rd_if.rd_ready = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL read_timeout: beats=%0d want %0d", beats, N);
    end
  endtask

  task automatic check_capture(input string tag);
    total++;
    if (capture_done !== 1'b1 || sample_count !== 8'(N) ||
        checksum !== 24'(sum_model)) begin
      bad++;
      $display("FAIL %s: done=%b cnt=%0d sum=%h want 1 %0d %h",
               tag, capture_done, sample_count, checksum,
               N, 24'(sum_model));
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    total++;
    if ({capture_done, sample_count, checksum, overflow,
         rd_if.rd_valid, rd_if.rd_data, rd_if.rd_last} !== '0) begin
      bad++;
      $display("FAIL reset: done=%b cnt=%0d sum=%h ovf=%b v=%b",
               capture_done, sample_count, checksum, overflow,
               rd_if.rd_valid);
    end
    #3 resetn = 1'b1;
    tick();
    clk_enable = 1'b1;
    Output1 = 16'h0055;
    tick();
    clk_enable = 1'b0;
    total++;
    if (sample_count !== 8'd0 || checksum !== 24'd0) begin
      bad++;
      $display("FAIL idle_strobe: cnt=%0d sum=%h want 0 0",
               sample_count, checksum);
    end
  endtask

  task automatic test_basic();
    int cyc, beats;
    arm_pulse();
    feed(N, 0, 0, 0);
    check_capture("basic_cap");
    total++;
    if (checksum !== 24'h007995) begin
      bad++;
      $display("FAIL basic_sum: got %h want 007995", checksum);
    end
    read_out(0, -1, cyc, beats);
    total++;
    if (beats !== N || cyc !== N + 1) begin
      bad++;
      $display("FAIL basic_read: beats=%0d cyc=%0d want %0d %0d",
               beats, cyc, N, N + 1);
    end
  endtask

  task automatic test_gapped_negative();
    arm_pulse();
    feed(N, 1, 2, 0);
    check_capture("neg_cap");
    total++;
    if (checksum !== 24'hFF0600 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL neg_sum: sum=%h ovf=%b want ff0600 0",
               checksum, overflow);
    end
  endtask

  task automatic test_overflow();
    int cyc, beats;
    for (int i = 0; i < 5; i++) begin
      clk_enable = 1'b1;
      Output1 = 16'h1234;
      tick();
    end
    clk_enable = 1'b0;
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_set: got %b want 1", overflow);
    end
    check_capture("ovf_cap");
    read_out(0, -1, cyc, beats);
    total++;
    if (beats !== N) begin
      bad++;
      $display("FAIL ovf_read: beats=%0d want %0d", beats, N);
    end
    arm_pulse();
    total++;
    if (overflow !== 1'b0 || sample_count !== 8'd0) begin
      bad++;
      $display("FAIL ovf_clear: ovf=%b cnt=%0d want 0 0",
               overflow, sample_count);
    end
  endtask

  task automatic test_back_pressure();
    int cyc, beats;
    arm_pulse();
    feed(N, 2, 3, 1);
    check_capture("bp_cap");
    read_out(1, -1, cyc, beats);
    total++;
    if (beats !== N) begin
      bad++;
      $display("FAIL bp_beats: got %0d want %0d", beats, N);
    end
  endtask

  task automatic test_abort();
    int cyc, beats;
    arm_pulse();
    feed(100, 2, 1, 1);
    total++;
    if (sample_count !== 8'd100 ||
        checksum !== 24'(sum_model) || capture_done !== 1'b0) begin
      bad++;
      $display("FAIL part_cap: cnt=%0d sum=%h want 100 %h",
               sample_count, checksum, 24'(sum_model));
    end
    arm_pulse();
    total++;
    if (sample_count !== 8'd0 || checksum !== 24'd0) begin
      bad++;
      $display("FAIL rearm: cnt=%0d sum=%h want 0 0",
               sample_count, checksum);
    end
    feed(N, 2, 0, 0);
    check_capture("abort_cap1");
    read_out(0, 10, cyc, beats);
    feed(N, 2, 2, 1);
    check_capture("abort_cap2");
    read_out(1, -1, cyc, beats);
    total++;
    if (beats !== N) begin
      bad++;
      $display("FAIL abort_read: beats=%0d want %0d", beats, N);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, beats;
    arm_pulse();
    feed(120, 2, 0, 0);
    resetn = 1'b0;
    #1;
    total++;
    if ({capture_done, sample_count, checksum, overflow,
         rd_if.rd_valid, rd_if.rd_data, rd_if.rd_last} !== '0) begin
      bad++;
      $display("FAIL mid_reset: cnt=%0d sum=%h d=%h want 0",
               sample_count, checksum, rd_if.rd_data);
    end
    #2 resetn = 1'b1;
    tick();
    arm_pulse();
    feed(N, 2, 1, 1);
    check_capture("post_reset_cap");
    read_out(0, -1, cyc, beats);
    total++;
    if (beats !== N || cyc !== N + 1) begin
      bad++;
      $display("FAIL post_reset_read: beats=%0d cyc=%0d", beats, cyc);
    end
  endtask

  initial begin
    resetn = 1'b0;
    arm = 1'b0;
    clk_enable = 1'b0;
    Output1 = '0;
    start_read = 1'b0;
    rd_if.rd_ready = 1'b0;
    sum_model = 0;
    test_reset();
    test_basic();
    test_gapped_negative();
    test_overflow();
    test_back_pressure();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
